microc_stack: RTL
=================

// Module: microc_stack
// PURPOSE
//  Parametrised single-cycle microcontroller datapath, the successor to the fixed 8-bit core.
//  - Instruction and data widths are parametrised.
//  - Program memory is external and read combinationally.
//  - Adds a carry flag and a hardware return-address stack for call/ret.
//  - Driven every cycle by the external control unit, which decodes Opcode, z and c.
// PARAMETERS
//  DW      8   data / register width in bits
//  RAW     4   register-address width; 2**RAW registers, r0 hard-wired to zero
//  PCW     10  program-counter width
//  SDEPTH  8   return-stack depth in entries, power of two, >= 2
//  IW (localparam) = 6 + max(PCW, DW+RAW, 3*RAW); 18 with defaults
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        asynchronous reset, active-low
//  instr      in   IW       instruction word from program memory at address pc
//  s_inc      in   1        1: next PC = pc+1; 0: next PC = target
//  s_inm      in   1        1: register write data = imm; 0: write data = ALU result
//  we3        in   1        register-file write enable
//  wez        in   1        flag (z, c) update enable
//  Op         in   3        ALU operation select
//  push       in   1        call: push pc+1, jump to target (s_inc ignored)
//  pop        in   1        ret: next PC = top of stack (s_inc ignored)
//  pc         out  PCW      current program counter (program-memory address)
//  Opcode     out  6        instr[IW-1:IW-6]
//  z          out  1        zero flag
//  c          out  1        carry flag
//  stk_empty  out  1        stack holds 0 entries
//  stk_full   out  1        stack holds SDEPTH entries
//  stk_err    out  1        sticky stack-error flag
// BEHAVIOUR
//  Fields
//  - target = instr[PCW-1:0]
//  - imm = instr[DW+RAW-1:RAW]
//  - ra1 = instr[3*RAW-1:2*RAW]
//  - ra2 = instr[2*RAW-1:RAW]
//  - wa3 = instr[RAW-1:0]
//  Reset (reset=0, asynchronous)
//  - pc=0, z=0, c=0, stack pointer=0, stk_err=0.
//  - All registers are cleared to 0.
//  - Outputs take these values immediately and hold them until the first rising edge after release.
//  Register file
//  - Two combinational read ports.
//  - One write port at the rising edge when we3=1.
//  - r0 always reads 0; writes to r0 are discarded.
//  - Read and write of the same register in one cycle returns the old value.
//  ALU (A=rd1, B=rd2, DW bits)
//  - 000 A
//  - 001 ~A
//  - 010 A+B (c = carry out)
//  - 011 A-B (c = 1 when a borrow occurs, i.e. A<B unsigned)
//  - 100 A&B
//  - 101 A|B
//  - 110 -A
//  - 111 -B
//  - c=0 for every op other than 010 and 011.
//  Flags
//  - When wez=1, z and c are registered at the rising edge; z = (ALU result == 0).
//  - When wez=0, both hold.
//  - Flags update independently of we3 and s_inm.
//  Next-PC priority at each rising edge
//  1. pop=1 and push=1: illegal. No stack change, stk_err<=1, PC <= pc (stall).
//  2. pop=1, stack empty: underflow. stk_err<=1, PC <= pc.
//  3. pop=1, otherwise: PC <= top entry; stack pointer decrements.
//  4. push=1, stack full: overflow. stk_err<=1, PC <= pc; no entry written.
//  5. push=1, otherwise: entry[sp] <= pc+1; sp increments; PC <= target.
//  6. Neither: PC <= s_inc ? pc+1 : target.
//  PC and stack rules
//  - pc+1 wraps modulo 2**PCW; a pushed return address wraps the same way.
//  - Register and flag writes still happen in stall cycles; the control unit must not assert them there.
//  - stk_err clears only on reset.
//  - stk_empty and stk_full are combinational from the stack pointer (SDEPTH+1 states).
//  Latency
//  - Single cycle: instr for pc is consumed in the same cycle.
//  - Register, flag, PC and stack results are visible after the next rising edge.
// TESTING
//  - Reset: reset=0 mid-run with pc=0x155 and r5=0x3C -> pc=0, z=0, c=0, stk_empty=1, stk_err=0 with no clock edge; r5 reads 0 afterwards.
//  - Immediate then add: load r1=0xF0 and r2=0x20 (s_inm=1, we3=1); then Op=010 into r3 with wez=1 -> r3=0x10, c=1, z=0. Then Op=011 with A=B=r3 -> z=1, c=0.
//  - r0: write 0xAA to r0 -> reads 0. Op=000 on r0 with wez=1 -> z=1.
//  - Nested calls: push at pc=0x010 (target 0x100), push at 0x100 (target 0x200), then pop twice -> pc 0x100 -> 0x200 -> 0x101 -> 0x011; stk_empty=1 at the end.
//  - Overflow: SDEPTH=8, nine consecutive pushes -> the ninth holds pc and sets stk_err=1, stk_full=1. A following pop returns the eighth return address; stk_err stays 1.
//  - Underflow, illegal op and wrap: pop on an empty stack -> pc unchanged, stk_err=1. push&pop together -> pc unchanged. pc=0x3FF with s_inc=1 -> pc=0x000.

Source files
------------

// File: rtl/microc_stack.sv
// Parametrised single-cycle microcontroller datapath: register file, ALU with
// zero/carry flags, program counter and a hardware return-address stack.
module microc_stack #(
  parameter int DW     = 8,
  parameter int RAW    = 4,
  parameter int PCW    = 10,
  parameter int SDEPTH = 8,
  localparam int M1    = (PCW > DW + RAW) ? PCW : DW + RAW,
  localparam int IW    = 6 + ((M1 > 3 * RAW) ? M1 : 3 * RAW)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] instr,
  input  logic          s_inc,
  input  logic          s_inm,
  input  logic          we3,
  input  logic          wez,
  input  logic [2:0]    Op,
  input  logic          push,
  input  logic          pop,
  output logic [PCW-1:0] pc,
  output logic [5:0]    Opcode,
  output logic          z,
  output logic          c,
  output logic          stk_empty,
  output logic          stk_full,
  output logic          stk_err
);

  localparam int NREG = 2 ** RAW;
  localparam int SIW  = $clog2(SDEPTH);
  localparam int SPW  = SIW + 1;

  logic [NREG-1:0][DW-1:0]    rf_q, rf_d;
  logic [SDEPTH-1:0][PCW-1:0] stk_q, stk_d;
  logic [PCW-1:0]             pc_q, pc_d;
  logic [SPW-1:0]             sp_q, sp_d;
  logic                       z_q, z_d, c_q, c_d, err_q, err_d;

  logic [PCW-1:0] target, pc_inc;
  logic [DW-1:0]  imm, rd1, rd2, alu_res, wdata;
  logic [RAW-1:0] ra1, ra2, wa3;
  logic [DW:0]    sum, diff;
  logic           alu_c;
  logic [SPW-1:0] sp_dec;
  logic [SIW-1:0] top_idx;

  assign target = instr[PCW-1:0];
  assign imm    = instr[DW+RAW-1:RAW];
  assign ra1    = instr[3*RAW-1:2*RAW];
  assign ra2    = instr[2*RAW-1:RAW];
  assign wa3    = instr[RAW-1:0];
  assign Opcode = instr[IW-1:IW-6];

  // Register file reads and ALU
  always_comb begin
    rd1     = (ra1 == '0) ? '0 : rf_q[ra1];
    rd2     = (ra2 == '0) ? '0 : rf_q[ra2];
    sum     = {1'b0, rd1} + {1'b0, rd2};
    diff    = {1'b0, rd1} - {1'b0, rd2};
    alu_res = '0;
    alu_c   = 1'b0;
    case (Op)
      3'b000: alu_res = rd1;
      3'b001: alu_res = ~rd1;
      3'b010: begin alu_res = sum[DW-1:0];  alu_c = sum[DW];  end
      3'b011: begin alu_res = diff[DW-1:0]; alu_c = diff[DW]; end
      3'b100: alu_res = rd1 & rd2;
      3'b101: alu_res = rd1 | rd2;
      3'b110: alu_res = -rd1;
      3'b111: alu_res = -rd2;
      default: alu_res = '0;
    endcase
    wdata = s_inm ? imm : alu_res;
  end

  always_comb begin
    rf_d = rf_q;
    if (we3 && wa3 != '0) rf_d[wa3] = wdata;
    z_d = wez ? (alu_res == '0) : z_q;
    c_d = wez ? alu_c : c_q;
  end

  assign stk_empty = (sp_q == '0);
  assign stk_full  = (sp_q == SPW'(SDEPTH));
  assign sp_dec    = sp_q - SPW'(1);
  assign top_idx   = sp_dec[SIW-1:0];
  assign pc_inc    = pc_q + PCW'(1);

  // Next PC / stack; faulting stack ops stall the PC and latch the error
  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    stk_d = stk_q;
    err_d = err_q;
    if (pop && push) begin
      err_d = 1'b1;
    end else if (pop) begin
      if (stk_empty) err_d = 1'b1;
      else begin
        pc_d = stk_q[top_idx];
        sp_d = sp_dec;
      end
    end else if (push) begin
      if (stk_full) err_d = 1'b1;
      else begin
        stk_d[sp_q[SIW-1:0]] = pc_inc;
        sp_d = sp_q + SPW'(1);
        pc_d = target;
      end
    end else begin
      pc_d = s_inc ? pc_inc : target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_q  <= '0;
      stk_q <= '0;
      pc_q  <= '0;
      sp_q  <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rf_q  <= rf_d;
      stk_q <= stk_d;
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      z_q   <= z_d;
      c_q   <= c_d;
      err_q <= err_d;
    end
  end

  assign pc      = pc_q;
  assign z       = z_q;
  assign c       = c_q;
  assign stk_err = err_q;

endmodule
